ir_fetch_ctrl: RTL
==================

Name: ir_fetch_ctrl

Overview:
- Sequences a multi-byte instruction fetch over the 8-bit memory bus into the bank of 8-bit instruction-register byte slices.
- Issues one memory request per byte with a req/ack handshake and generates one-hot load strobes for the byte registers.
- Sits between the control unit, which starts and flushes fetches, and the instruction register file plus memory interface.
- Reports completion to decode through ir_valid and a done pulse.

Parameters:
- NBYTES, 4, number of instruction bytes per fetch (2..8).
- ADDR_W, 8, memory address width.
- TIMEOUT, 15, maximum wait cycles for mem_ack. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  fetch request from the control unit; sampled in IDLE only.
- flush  input  1  synchronous abort; highest priority after rst.
- pc  input  ADDR_W  instruction base address, captured when start is accepted.
- mem_req  output  1  memory request strobe.
- mem_addr  output  ADDR_W  byte address of the current request.
- mem_ack  input  1  memory acknowledge; data on the bus is valid in the same cycle.
- ld  output  NBYTES  one-hot load strobes to the byte registers; ld[0] is the most-significant byte.
- busy  output  1  high in REQ and DONE.
- done  output  1  one-cycle pulse when the last byte has been loaded.
- ir_valid  output  1  instruction register holds a complete instruction.
- err  output  1  sticky fetch timeout flag; constant 0 when FETCH_TIMEOUT_EN is undefined.

Behaviour:
- Reset (async): state=IDLE, idx=0, base=0. All outputs are 0: mem_req, mem_addr, ld, busy, done, ir_valid, err.
- State machine states: IDLE, REQ, DONE. The state is registered; ld is combinational.
- IDLE:
  - start=1 and flush=0: capture base<=pc, set idx<=0, clear ir_valid, go to REQ.
  - Otherwise remain in IDLE.
- REQ:
  - mem_req=1.
  - mem_addr = base + idx, truncated to ADDR_W. Addresses wrap modulo 2^ADDR_W; for example, base=0xFE with NBYTES=4 gives FE, FF, 00, 01.
  - ld[idx] = mem_req & mem_ack, so the byte register captures bus data on the same rising edge that completes the handshake. ld is never multi-hot.
  - mem_ack=1 and idx<NBYTES-1: idx<=idx+1, stay in REQ. mem_req stays high with no idle cycle between bytes.
  - mem_ack=1 and idx==NBYTES-1: go to DONE.
  - mem_ack=0: hold state, address and idx indefinitely.
- DONE:
  - Lasts one cycle: done=1, mem_req=0.
  - Next state is IDLE, with ir_valid<=1.
- ir_valid:
  - Stays 1 in IDLE until the next accepted start or a flush.
  - Latency from start to ir_valid is 1 + (number of REQ cycles) + 1, i.e. a minimum of NBYTES+2 cycles with zero-wait ack.
- start outside IDLE is ignored; there is no queuing.
- mem_ack outside REQ is ignored, and no ld is generated.
- flush=1 in any state: next state is IDLE, idx<=0, ir_valid<=0, ld forced to 0 in the same cycle.
  - Bytes already loaded remain in the byte registers but are not valid.
  - flush together with start in IDLE: flush wins and start is dropped.
- rst during REQ: immediate return to reset values. The handshake is abandoned, and memory must tolerate mem_req dropping without an ack.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter (width clog2(TIMEOUT+1)) clears on entering REQ and on each ack, and increments each REQ cycle with mem_ack=0.
  - When the counter reaches TIMEOUT with mem_ack still 0: err<=1 (sticky), go to IDLE, ir_valid stays 0, no done pulse.
  - err clears only on rst or on the next accepted start.
  - An ack arriving in the same cycle as the counter reaching TIMEOUT takes priority over the timeout.
- Undefined: no counter logic; err is tied to 0; REQ waits forever.

Test Plan:
- Zero-wait fetch: NBYTES=4, pc=0x10, mem_ack held 1, start pulsed at cycle 0 -> mem_addr 10, 11, 12, 13 on cycles 1-4; ld = 0001, 0010, 0100, 1000; done=1 at cycle 5; ir_valid=1 from cycle 6.
- Wait states: ack delayed 2 cycles on byte 1 -> mem_addr holds 0x11 for 3 cycles; ld[1] pulses exactly once; done at cycle 7.
- Wrap-around: pc=0xFE -> addresses FE, FF, 00, 01; ir_valid=1 at the end.
- Flush mid-fetch: flush asserted on the cycle byte 2 is acked -> ld=0 that cycle; state IDLE next cycle; ir_valid=0; no done pulse. Also start while busy -> ignored, with no address change.
- Reset mid-REQ: rst asserted asynchronously between edges -> mem_req, ld and busy drop immediately; all outputs are 0.
- FETCH_TIMEOUT_EN with TIMEOUT=15: mem_ack held 0 -> err=1 after 15 wait cycles; state IDLE; ir_valid=0. A following start clears err, and a normal fetch then completes.

Source files
------------

// File: rtl/ir_fetch_ctrl.sv
// rtl/ir_fetch_ctrl.sv - multi-byte instruction fetch sequencer with per-byte req/ack and one-hot load strobes
// Optional: FETCH_TIMEOUT_EN enables the ack wait counter and sticky err flag.
module ir_fetch_ctrl #(
  parameter int NBYTES  = 4,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [NBYTES-1:0] ld,
  output logic              busy,
  output logic              done,
  output logic              ir_valid,
  output logic              err
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              ir_valid_q, ir_valid_d;
  logic              start_accept;
  logic              last_byte;
  logic              timeout;

  assign start_accept = (state_q == S_IDLE) && start && !flush;
  assign last_byte    = (idx_q == IDX_W'(NBYTES - 1));
  assign ir_valid     = ir_valid_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  logic [WCNT_W-1:0] wait_q;
  logic              err_q;

  // An ack in the same cycle as the limit wins, so timeout requires !mem_ack.
  assign timeout = (state_q == S_REQ) && !mem_ack && (wait_q == WCNT_W'(TIMEOUT));
  assign err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q != S_REQ || mem_ack || flush)
        wait_q <= '0;
      else if (!timeout)
        wait_q <= wait_q + 1'b1;
      if (start_accept)
        err_q <= 1'b0;
      else if (timeout && !flush)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    base_d     = base_q;
    ir_valid_d = ir_valid_q;
    mem_req    = 1'b0;
    mem_addr   = '0;
    ld         = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          base_d     = pc;
          idx_d      = '0;
          ir_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = base_q + ADDR_W'(idx_q);
        if (mem_ack) begin
          ld = NBYTES'(1) << idx_q;
          if (last_byte)
            state_d = S_DONE;
          else
            idx_d = idx_q + 1'b1;
        end else if (timeout) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_d    = S_IDLE;
        ir_valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything above, including a same-cycle byte load.
    if (flush) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      ir_valid_d = 1'b0;
      ld         = '0;
    end
  end

endmodule
